// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake between the MEM stage and the load/store unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator with alignment check, lane steering and load extension
module mem_access_unit #(
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic                     clk,
    input  logic                     clr,
    mem_access_unit_if.slave         bus,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [31:0]              mem_data_in,
    output logic                     mem_str,
    output logic [3:0]               mem_sel,
    output logic                     mem_ld,
    input  logic [31:0]              mem_data_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t                   state_q;
    logic                     we_q, uns_q, err_q, valid_q, str_q, ld_q;
    logic [1:0]               size_q, off_q;
    logic [3:0]               sel_q;
    logic [31:0]              din_q, rdata_q;
    logic [MEM_ADDR_BITS-1:0] addr_q;
    logic                     bad;
    logic [3:0]               sel_d;
    logic [31:0]              din_d, sh, ext;
    logic                     unused_addr;
    assign unused_addr = ^bus.req_addr[31:MEM_ADDR_BITS+2];
    assign bad = bus.req_size == 2'd3 || (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                 (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);
    assign sel_d = bus.req_size == 2'd0 ? 4'b0001 << bus.req_addr[1:0] :
                   bus.req_size == 2'd1 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign din_d = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} :
                   bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    assign sh  = mem_data_out >> {off_q, 3'b000};
    assign ext = size_q == 2'd0 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
                 size_q == 2'd1 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
    assign bus.req_ready  = state_q == IDLE && !clr;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = din_q;
    assign mem_str     = str_q;
    assign mem_sel     = sel_q;
    assign mem_ld      = ld_q;
    // Memory strobes are registered so the async clear drops them mid-ISSUE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            str_q   <= 1'b0;
            ld_q    <= 1'b0;
            size_q  <= 2'd0;
            off_q   <= 2'd0;
            sel_q   <= 4'd0;
            din_q   <= 32'd0;
            rdata_q <= 32'd0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    uns_q   <= bus.req_unsigned;
                    size_q  <= bus.req_size;
                    off_q   <= bus.req_addr[1:0];
                    err_q   <= bad;
                    rdata_q <= 32'd0;
                    valid_q <= bad;
                    state_q <= bad ? RESP : ISSUE;
                    if (!bad) begin
                        addr_q <= bus.req_addr[MEM_ADDR_BITS+1:2];
                        sel_q  <= sel_d;
                        str_q  <= bus.req_we;
                        ld_q   <= ~bus.req_we;
                        din_q  <= bus.req_we ? din_d : 32'd0;
                    end
                end
                ISSUE: begin
                    str_q   <= 1'b0;
                    ld_q    <= 1'b0;
                    sel_q   <= 4'd0;
                    din_q   <= 32'd0;
                    valid_q <= we_q;
                    state_q <= we_q ? RESP : CAPTURE;
                end
                CAPTURE: begin
                    rdata_q <= ext;
                    valid_q <= 1'b1;
                    state_q <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
